// File: rtl/rvfi_rm_cmd_gen.sv
// Turns each RVFI retirement into a queued STEP / INTR / DEBUG command for the
// reference-model consumer. Async events carry how many retirements to revert.
module rvfi_rm_cmd_gen #(
    parameter int DEPTH      = 8,
    parameter int REVERT_W   = 4,
    parameter int MAX_REVERT = 15
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       rvfi_valid_i,
    input  logic                       rvfi_intr_i,
    input  logic [2:0]                 rvfi_dbg_i,
    input  logic [31:0]                irq_i,
    input  logic [31:0]                mie_i,
    input  logic                       debug_req_i,
    output logic                       cmd_valid_o,
    input  logic                       cmd_ready_i,
    output logic [1:0]                 cmd_type_o,
    output logic [31:0]                cmd_mip_o,
    output logic [31:0]                cmd_mie_o,
    output logic                       cmd_debug_req_o,
    output logic [REVERT_W-1:0]        cmd_revert_o,
    output logic                       cmd_allowed_o,
    output logic [$clog2(DEPTH):0]     fifo_count_o,
    output logic                       overflow_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(DEPTH);
    localparam logic [REVERT_W-1:0] SAT_CNT  = REVERT_W'(MAX_REVERT);

    typedef enum logic [1:0] {
        CMD_STEP  = 2'd0,
        CMD_INTR  = 2'd1,
        CMD_DEBUG = 2'd2
    } cmd_type_t;

    typedef struct packed {
        cmd_type_t             ctype;
        logic [31:0]           mip;
        logic [31:0]           mie;
        logic                  debug_req;
        logic [REVERT_W-1:0]   revert;
        logic                  allowed;
    } entry_t;

    logic [31:0]         irq_prev_reg, irq_snap_reg;
    logic                dbg_prev_reg;
    logic [REVERT_W-1:0] irq_cnt_reg, irq_cnt_next;
    logic [REVERT_W-1:0] dbg_cnt_reg, dbg_cnt_next;
    logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]    count_reg, count_next;
    logic                overflow_reg;
    entry_t              mem [DEPTH];
    entry_t              entry_next, head;

    logic irq_change, dbg_rise, is_dbg, is_intr, push, pop, push_ok;

    assign irq_change = (irq_i != irq_prev_reg);
    assign dbg_rise   = debug_req_i & ~dbg_prev_reg;
    assign is_dbg     = rvfi_valid_i & (rvfi_dbg_i != 3'd0);
    assign is_intr    = rvfi_valid_i & ~is_dbg & rvfi_intr_i;

    assign cmd_valid_o = (count_reg != '0);
    assign push        = rvfi_valid_i;
    assign pop         = cmd_valid_o & cmd_ready_i;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok     = push & ((count_reg != FULL_CNT) | pop);

    always_comb begin
        entry_next           = '0;
        entry_next.mie       = mie_i;
        entry_next.debug_req = debug_req_i;
        if (is_dbg) begin
            entry_next.ctype   = CMD_DEBUG;
            entry_next.mip     = irq_snap_reg;
            entry_next.revert  = dbg_cnt_reg;
            entry_next.allowed = 1'b1;
        end else if (is_intr) begin
            entry_next.ctype   = CMD_INTR;
            entry_next.mip     = irq_snap_reg;
            entry_next.revert  = irq_cnt_reg;
            entry_next.allowed = 1'b1;
        end
    end

    always_comb begin
        irq_cnt_next = irq_cnt_reg;
        if (irq_change || is_intr)
            irq_cnt_next = '0;
        else if (rvfi_valid_i && irq_cnt_reg != SAT_CNT)
            irq_cnt_next = irq_cnt_reg + REVERT_W'(1);

        dbg_cnt_next = dbg_cnt_reg;
        if (dbg_rise || is_dbg)
            dbg_cnt_next = '0;
        else if (rvfi_valid_i && dbg_cnt_reg != SAT_CNT)
            dbg_cnt_next = dbg_cnt_reg + REVERT_W'(1);
    end

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_prev_reg <= '0;
            irq_snap_reg <= '0;
            dbg_prev_reg <= 1'b0;
            irq_cnt_reg  <= '0;
            dbg_cnt_reg  <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            irq_prev_reg <= irq_i;
            if (irq_change)
                irq_snap_reg <= irq_i;
            dbg_prev_reg <= debug_req_i;
            irq_cnt_reg  <= irq_cnt_next;
            dbg_cnt_reg  <= dbg_cnt_next;
            count_reg    <= count_next;
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (push && !push_ok)
                overflow_reg <= 1'b1;
        end
    end

    // Storage is not reset; the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_ok)
            mem[wr_ptr_reg] <= entry_next;
    end

    assign head = cmd_valid_o ? mem[rd_ptr_reg] : '0;

    assign cmd_type_o      = head.ctype;
    assign cmd_mip_o       = head.mip;
    assign cmd_mie_o       = head.mie;
    assign cmd_debug_req_o = head.debug_req;
    assign cmd_revert_o    = head.revert;
    assign cmd_allowed_o   = head.allowed;
    assign fifo_count_o    = count_reg;
    assign overflow_o      = overflow_reg;
endmodule

// File: doc/rvfi_rm_cmd_gen.md
# rvfi_rm_cmd_gen

Bridges the DUT's RVFI retirement stream to the Spike reference model. Each retirement becomes a queued command (STEP, INTR or DEBUG) for the testbench-side consumer. INTR and DEBUG commands carry the mip/mie snapshot, the debug request, and the number of already-retired instructions the ISS must revert before applying the asynchronous event. The block sits next to the RVFI tap in the core testbench; its output FIFO is drained by the consumer that drives the ISS step/interrupt/debug/revert calls.

## Interface
- DEPTH, 8: command FIFO entries, power of two, ≥2
- REVERT_W, 4: width of revert counters
- MAX_REVERT, 15: saturation value of revert counters (≤ 2^REVERT_W−1)
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- rvfi_valid_i  in  1  one instruction retired this cycle
- rvfi_intr_i  in  1  retired instruction is first of an interrupt handler
- rvfi_dbg_i  in  3  debug-entry cause of retired instruction; 0 = none
- irq_i  in  32  DUT interrupt lines (mip view)
- mie_i  in  32  DUT mie CSR
- debug_req_i  in  1  DUT debug request
- cmd_valid_o  out  1  head entry valid
- cmd_ready_i  in  1  consumer accepts head entry
- cmd_type_o  out  2  0 = STEP, 1 = INTR, 2 = DEBUG
- cmd_mip_o  out  32  mip snapshot
- cmd_mie_o  out  32  mie at retirement
- cmd_debug_req_o  out  1  debug_req level at retirement
- cmd_revert_o  out  REVERT_W  steps to revert before event
- cmd_allowed_o  out  1  event allowed
- fifo_count_o  out  $clog2(DEPTH)+1  occupancy
- overflow_o  out  1  sticky: an entry was dropped

## Operation
- Registers:
  - irq_prev, irq_snap (32b)
  - dbg_prev
  - irq_cnt, dbg_cnt (REVERT_W)
  - FIFO storage, wr/rd pointers, count
  - overflow flag
- irq tracking:
  - irq_i ≠ irq_prev → irq_snap ← irq_i; irq_cnt ← 0.
  - Otherwise, each rvfi_valid_i increments irq_cnt, saturating at MAX_REVERT.
  - irq_prev ← irq_i every cycle.
  - An irq change wins over a same-cycle retirement: the counter ends at 0.
- debug tracking:
  - Rising edge of debug_req_i (debug_req_i & !dbg_prev) → dbg_cnt ← 0.
  - Otherwise, each retirement increments dbg_cnt, saturating at MAX_REVERT.
- Entry formation on rvfi_valid_i, in priority order:
  - rvfi_dbg_i ≠ 0 → DEBUG. revert = dbg_cnt (pre-update value). dbg_cnt ← 0 next cycle.
  - else rvfi_intr_i → INTR. mip = irq_snap, revert = irq_cnt (pre-update value). irq_cnt ← 0 next cycle unless an irq change forces 0 anyway.
  - else → STEP. revert = 0.
- Entry fields:
  - mie = mie_i and debug_req = debug_req_i, sampled this cycle.
  - allowed = 1 for INTR/DEBUG, 0 for STEP.
- Consumer contract: INTR means "apply interrupt with revert, then step once". DEBUG is the same for debug.
- FIFO push:
  - A push is accepted when count < DEPTH, or when count = DEPTH and a pop occurs this cycle.
  - Otherwise the entry is dropped and overflow_o ← 1. overflow_o clears only on reset.
- Pop: cmd_valid_o & cmd_ready_i.
- Pointer wrap-around at DEPTH uses natural binary wrap.
- Reset (rst_i=1 at clk edge) produces:
  - FIFO empty: cmd_valid_o=0, fifo_count_o=0
  - overflow_o=0
  - irq_cnt = dbg_cnt = 0
  - irq_prev = irq_snap = 0, dbg_prev = 0
  - Data outputs read 0 (type STEP, mip/mie/revert/allowed/debug_req = 0).
- Reset mid-operation discards all queued entries. Retirements in the reset cycle are ignored.

## Timing
- Push-to-valid latency is 1 cycle. An entry pushed at edge N is visible on cmd_* after edge N; the FIFO is registered, with no fall-through in the push cycle.
- cmd_* is stable while cmd_valid_o & !cmd_ready_i.
- Throughput is one push and one pop per cycle. Simultaneous push and pop leaves count unchanged.
- Empty plus push-and-ready: the entry is valid next cycle and popped that cycle if ready is held.
- irq_i is compared every cycle regardless of rvfi_valid_i. irq_snap therefore reflects the most recent change before the retiring edge.
- fifo_count_o is registered and updates the cycle after push/pop.

## Test plan
- **Reset values:** hold rst_i 2 cycles with rvfi_valid_i=1 → cmd_valid_o=0, fifo_count_o=0, overflow_o=0, all cmd_* fields 0.
- **STEP stream:** 3 retirements, cmd_ready_i=1 → 3 STEP entries, revert=0, each valid one cycle after its retirement.
- **INTR revert count:** irq_i 0→0x800, 2 plain retirements, then retirement with rvfi_intr_i=1, mie_i=0x888 → STEP, STEP, then INTR with mip=0x800, mie=0x888, revert=2, allowed=1. Next INTR without irq change has revert equal to retirements since the previous INTR.
- **Saturation and change priority:** 20 retirements after an irq change, then INTR → revert=15. Irq change in the same cycle as a retirement → irq_cnt=0.
- **DEBUG priority:** debug_req_i rises, 1 retirement, then retirement with rvfi_dbg_i=3 and rvfi_intr_i=1 → DEBUG entry, revert=1, debug_req=1.
- **Full and overflow:** cmd_ready_i=0, DEPTH+1 retirements → fifo_count_o=DEPTH, overflow_o=1, first DEPTH entries preserved in order. Pop and push in the same cycle while full → accepted, count stays DEPTH.
